// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller and SystemRegisters:
// FSM encoding, device limits, PCS bit positions and the priority helper.
package interrupt_controller_pkg;

  localparam int unsigned MAX_NDEV = 16;
  localparam int unsigned IDX_W    = 4;

  // PCS bit positions, shared with SystemRegisters
  localparam int unsigned PCS_IE  = 0;
  localparam int unsigned PCS_OIE = 1;
  localparam int unsigned PCS_CM  = 4;
  localparam int unsigned PCS_OM  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } ic_state_e;

  // Index of the lowest set bit; index 0 has the highest priority
  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_NDEV-1:0] v);
    lowest_set = '0;
    for (int i = MAX_NDEV - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/interrupt_controller_irq_sync.sv
// Synchronizes one asynchronous IRQ line and produces a one-cycle rising-edge
// pulse from the synchronized level.
module interrupt_controller_irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_i,
  output logic rise_c_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Combinational so the pending latch sets SYNC_STAGES+1 cycles after the rise
  assign rise_c_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// Latches device interrupts as pending, picks one by fixed priority and runs the
// request/acknowledge handshake with the pipeline memory stage.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned BITS        = 32,
  parameter int unsigned NDEV        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IDN_BASE    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NDEV-1:0] irq_i,
  input  logic            ie_i,
  input  logic            mask_we_i,
  input  logic [BITS-1:0] mask_in_i,
  output logic            int_req_o,
  input  logic            int_ack_i,
  output logic [BITS-1:0] idn_o,
  output logic [NDEV-1:0] dev_ack_o,
  output logic [NDEV-1:0] mask_o,
  output logic [NDEV-1:0] pending_o
);

  ic_state_e        state_q, state_d;
  logic [NDEV-1:0]  rise_c;
  logic [NDEV-1:0]  elig_c;
  logic [IDX_W-1:0] win_idx_c;
  logic [NDEV-1:0]  grant_q, grant_d;
  logic [NDEV-1:0]  pending_q, pending_d;
  logic [NDEV-1:0]  mask_q, mask_d;
  logic [NDEV-1:0]  dev_ack_q, dev_ack_d;
  logic [BITS-1:0]  idn_q, idn_d;
  logic             int_req_q, int_req_d;
  logic             unused_mask_bits;

  for (genvar g = 0; g < NDEV; g++) begin : g_sync
    interrupt_controller_irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .irq_i   (irq_i[g]),
      .rise_c_o(rise_c[g])
    );
  end

  assign elig_c           = pending_q & mask_q;
  assign win_idx_c        = lowest_set(MAX_NDEV'(elig_c));
  assign unused_mask_bits = ^mask_in_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      dev_ack_q <= '0;
      idn_q     <= '0;
      int_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      dev_ack_q <= dev_ack_d;
      idn_q     <= idn_d;
      int_req_q <= int_req_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idn_d     = idn_q;
    dev_ack_d = '0;
    mask_d    = mask_we_i ? mask_in_i[NDEV-1:0] : mask_q;
    pending_d = pending_q | rise_c;

    unique case (state_q)
      ST_IDLE: begin
        if (ie_i && (|elig_c)) begin
          state_d = ST_REQ;
          idn_d   = BITS'(win_idx_c) + BITS'(IDN_BASE);
          grant_d = NDEV'(1) << win_idx_c;
        end
      end
      // Grant is frozen here; a withdrawn request keeps its pending bit
      ST_REQ: begin
        if (int_ack_i) begin
          state_d   = ST_ACK;
          dev_ack_d = grant_q;
        end else if (!ie_i || ((elig_c & grant_q) == '0)) begin
          state_d = ST_IDLE;
        end
      end
      // A fresh edge on the granted line in this cycle must survive the clear
      ST_ACK: begin
        state_d   = ST_IDLE;
        pending_d = (pending_q & ~grant_q) | rise_c;
      end
      default: state_d = ST_IDLE;
    endcase

    int_req_d = (state_d == ST_REQ);
  end

  assign int_req_o = int_req_q;
  assign idn_o     = idn_q;
  assign dev_ack_o = dev_ack_q;
  assign mask_o    = mask_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed vector table, hand
// sequences for multi-cycle corners, and randomized traffic against a model.
module tb_interrupt_controller;

  localparam int unsigned BITS = 32;
  localparam int unsigned NDEV = 4;
  localparam int unsigned SYNC = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NDEV-1:0] irq = '0;
  logic            ie = 1'b0;
  logic            mask_we = 1'b0;
  logic [BITS-1:0] mask_in = '0;
  logic            int_req;
  logic            int_ack = 1'b0;
  logic [BITS-1:0] idn;
  logic [NDEV-1:0] dev_ack;
  logic [NDEV-1:0] mask;
  logic [NDEV-1:0] pending;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  interrupt_controller #(
    .BITS(BITS), .NDEV(NDEV), .SYNC_STAGES(SYNC), .IDN_BASE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq), .ie_i(ie), .mask_we_i(mask_we),
    .mask_in_i(mask_in), .int_req_o(int_req), .int_ack_i(int_ack), .idn_o(idn),
    .dev_ack_o(dev_ack), .mask_o(mask), .pending_o(pending)
  );

  typedef struct {
    logic [3:0]  irq;
    logic        ie;
    logic        ack;
    logic        req;
    logic [3:0]  pend;
    logic [3:0]  dack;
    logic [31:0] idn;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (int_req !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk(name, 64'(int_req), 64'(1));
  endtask

  // Reference model state
  logic        m_req, m_ackph;
  logic [3:0]  m_grant, m_mask, m_pend;
  logic [31:0] m_idn;
  logic [3:0]  hist[$];

  task automatic model_reset();
    m_req = 0; m_ackph = 0; m_grant = '0; m_mask = 4'hF; m_pend = '0; m_idn = '0;
    hist = {};
    for (int i = 0; i <= SYNC; i++) hist.push_back(4'h0);
  endtask

  task automatic model_step(input logic [3:0] x, input logic e, input logic a,
                            input logic we, input logic [3:0] mi);
    logic [3:0] rise, elig;
    int idx;
    rise = hist[hist.size() - SYNC] & ~hist[hist.size() - SYNC - 1];
    hist.push_back(x);
    void'(hist.pop_front());
    elig = m_pend & m_mask;
    if (we) m_mask = mi;
    if (m_ackph) begin
      m_pend  = (m_pend & ~m_grant) | rise;
      m_ackph = 0;
    end else begin
      m_pend = m_pend | rise;
      if (m_req) begin
        if (a) begin
          m_req = 0; m_ackph = 1;
        end else if (!e || (elig & m_grant) == 0) begin
          m_req = 0;
        end
      end else if (e && elig != 0) begin
        idx = 0;
        while (!elig[idx]) idx++;
        m_req = 1; m_grant = 4'(1 << idx); m_idn = 32'(idx);
      end
    end
  endtask

  initial begin
    tbl[0]  = '{4'b0100, 1, 0, 0, 4'b0000, 4'b0000, 0};
    tbl[1]  = '{4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0};
    tbl[2]  = '{4'b0000, 1, 0, 0, 4'b0100, 4'b0000, 0};
    tbl[3]  = '{4'b0000, 1, 0, 1, 4'b0100, 4'b0000, 2};
    tbl[4]  = '{4'b0000, 1, 1, 0, 4'b0100, 4'b0100, 2};
    tbl[5]  = '{4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2};
    tbl[6]  = '{4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 2};
    tbl[7]  = '{4'b1010, 1, 0, 0, 4'b0000, 4'b0000, 2};
    tbl[8]  = '{4'b1010, 1, 0, 0, 4'b0000, 4'b0000, 2};
    tbl[9]  = '{4'b1010, 1, 0, 0, 4'b1010, 4'b0000, 2};
    tbl[10] = '{4'b1010, 1, 0, 1, 4'b1010, 4'b0000, 1};
    tbl[11] = '{4'b1010, 1, 1, 0, 4'b1010, 4'b0010, 1};
    tbl[12] = '{4'b1010, 0, 0, 0, 4'b1000, 4'b0000, 1};
    tbl[13] = '{4'b1010, 1, 0, 1, 4'b1000, 4'b0000, 3};
    tbl[14] = '{4'b1010, 1, 1, 0, 4'b1000, 4'b1000, 3};
    tbl[15] = '{4'b1010, 0, 0, 0, 4'b0000, 4'b0000, 3};
    tbl[16] = '{4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 3};
    tbl[17] = '{4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 3};
    tbl[18] = '{4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 3};
    tbl[19] = '{4'b0000, 0, 0, 0, 4'b0001, 4'b0000, 3};
    tbl[20] = '{4'b0000, 0, 0, 0, 4'b0001, 4'b0000, 3};
    tbl[21] = '{4'b0000, 1, 0, 1, 4'b0001, 4'b0000, 0};
    tbl[22] = '{4'b0000, 1, 1, 0, 4'b0001, 4'b0001, 0};
    tbl[23] = '{4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0};

    // Reset state
    #12;
    chk("reset_state", {int_req, idn, dev_ack, mask, pending}, {1'b0, 32'd0, 4'h0, 4'hF, 4'h0});
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Directed table: single device, simultaneous pair, IE gating
    for (int i = 0; i < 24; i++) begin
      irq = tbl[i].irq; ie = tbl[i].ie; int_ack = tbl[i].ack;
      cyc();
      chk($sformatf("vec%0d", i), {int_req, pending, dev_ack, idn},
          {tbl[i].req, tbl[i].pend, tbl[i].dack, tbl[i].idn});
    end

    // Masking away a requested device withdraws the request, pending kept
    irq = 4'b0100; ie = 1'b1;
    cyc();
    irq = '0;
    wait_req("mask_req_wait");
    chk("mask_req_idn", 64'(idn), 64'(2));
    mask_we = 1'b1; mask_in = 32'hFFFF_FFFB;
    cyc();
    mask_we = 1'b0;
    chk("mask_written", 64'(mask), 64'(4'b1011));
    chk("mask_req_held", 64'(int_req), 64'(1));
    cyc();
    chk("mask_req_drop", {int_req, pending}, {1'b0, 4'b0100});
    cyc();
    chk("mask_req_stays_low", 64'(int_req), 64'(0));
    mask_we = 1'b1; mask_in = 32'h0000_000F;
    cyc();
    mask_we = 1'b0;
    wait_req("unmask_req_wait");
    chk("unmask_idn", 64'(idn), 64'(2));

    // New edge on the granted line landing in the ACK exit cycle is kept
    irq = 4'b0100;
    cyc();
    int_ack = 1'b1;
    cyc();
    chk("ack_edge_dack", {int_req, dev_ack}, {1'b0, 4'b0100});
    int_ack = 1'b0; ie = 1'b0;
    cyc();
    chk("ack_edge_pend", {int_req, dev_ack, pending}, {1'b0, 4'b0000, 4'b0100});
    irq = '0; ie = 1'b1;
    cyc();
    chk("ack_edge_rereq", {int_req, idn}, {1'b1, 32'd2});
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0; ie = 1'b0;
    cyc();
    chk("ack_edge_clear", 64'(pending), 64'(0));

    // Asynchronous reset in the middle of a request
    ie = 1'b1; mask_we = 1'b1; mask_in = 32'h7;
    cyc();
    mask_we = 1'b0; irq = 4'b1010;
    cyc();
    irq = '0;
    wait_req("rst_req_wait");
    chk("rst_pre", {idn, pending, mask}, {32'd1, 4'b1010, 4'b0111});
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async", {int_req, idn, dev_ack, mask, pending}, {1'b0, 32'd0, 4'h0, 4'hF, 4'h0});
    int_ack = 1'b1;
    cyc();
    chk("rst_no_dack", {int_req, dev_ack}, {1'b0, 4'h0});
    int_ack = 1'b0; ie = 1'b0;
    #2 rst_n = 1'b1;

    // Randomized traffic against the reference model
    model_reset();
    for (int c = 0; c < 800; c++) begin
      logic [3:0] dack_e;
      for (int b = 0; b < NDEV; b++) if ($urandom_range(5) == 0) irq[b] = ~irq[b];
      ie      = ($urandom_range(7) != 0);
      int_ack = ($urandom_range(2) == 0);
      mask_we = ($urandom_range(15) == 0);
      mask_in = $urandom;
      model_step(irq, ie, int_ack, mask_we, mask_in[3:0]);
      dack_e = m_ackph ? m_grant : 4'h0;
      cyc();
      chk($sformatf("rand%0d", c), {int_req, idn, dev_ack, mask, pending},
          {m_req, m_idn, dack_e, m_mask, m_pend});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
